// File: rtl/asi_usr_ram_pkg.sv
// asi_usr_ram_pkg: shared constants, read-pipeline stage type and the
// transfer-size legality helper for the user-side RAM slave.
package asi_usr_ram_pkg;

  // Deepest read pipeline the slave supports (SLV_WS legal range 1..RD_PIPE_MAX).
  localparam int RD_PIPE_MAX = 4;

  // Data width of the asi user bus; the slave datapath is built to match it.
  localparam int ASI_DW = 128;

  // One read-pipeline stage: a valid marker travelling with its data word.
  typedef struct packed {
    logic              valid;
    logic [ASI_DW-1:0] data;
  } rd_stage_t;

  // A transfer size (log2 bytes) is illegal when it exceeds the word width
  // or falls below the smallest size the slave accepts.
  function automatic logic size_error(input logic [7:0]  size,
                                      input int unsigned bo,
                                      input int unsigned min_size);
    logic [31:0] sz;
    sz = {24'd0, size};
    return (sz > bo) || (sz < min_size);
  endfunction

endpackage

// File: rtl/asi_usr_ram_if.sv
// asi_usr_ram_if: usr_* bus between the asi slave (master side) and the
// user RAM (slave side).
interface asi_usr_ram_if #(
  parameter int AXI_DW = 128,
  parameter int AXI_AW = 40,
  parameter int AXI_SW = 3
);
  localparam int AXI_WSTRBW = AXI_DW / 8;

  logic [AXI_AW-1:0]     usr_a;
  logic                  usr_cen;
  logic [AXI_DW-1:0]     usr_d;
  logic [AXI_WSTRBW-1:0] usr_wen;
  logic [AXI_DW-1:0]     usr_q;
  logic [AXI_SW-1:0]     usr_wsize;
  logic [AXI_SW-1:0]     usr_rsize;
  logic                  usr_wsize_error;
  logic                  usr_rsize_error;

  modport master (
    output usr_a, usr_cen, usr_d, usr_wen, usr_wsize, usr_rsize,
    input  usr_q, usr_wsize_error, usr_rsize_error
  );

  modport slave (
    input  usr_a, usr_cen, usr_d, usr_wen, usr_wsize, usr_rsize,
    output usr_q, usr_wsize_error, usr_rsize_error
  );

endinterface

// File: rtl/asi_usr_ram_chk.sv
// asi_usr_ram_chk: simulation-only protocol checks on the usr_* bus.
module asi_usr_ram_chk (
  input logic clk,
  input logic rst_n,
  input logic cen
);

  // The access enable must always be a known value while out of reset.
  a_cen_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(cen));

endmodule

// File: rtl/asi_usr_ram_rdpipe.sv
// asi_usr_ram_rdpipe: DEPTH-stage valid/data shift register. The output
// register loads only when the last stage carries a valid word, so the
// result appears exactly DEPTH edges after the launching access edge.
module asi_usr_ram_rdpipe
  import asi_usr_ram_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              launch,
  input  logic [ASI_DW-1:0] rd_data,
  output logic [ASI_DW-1:0] q
);

  // Clamp into the supported range so a bad parameter cannot build a zero-length array.
  localparam int NST = (DEPTH < 1) ? 1 : ((DEPTH > RD_PIPE_MAX) ? RD_PIPE_MAX : DEPTH);

  rd_stage_t stage [NST];

  // Shift launched reads through the pipeline; idle cycles shift in an empty stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NST; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0].valid <= launch;
      stage[0].data  <= launch ? rd_data : {ASI_DW{1'b0}};
      for (int i = 1; i < NST; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  // Output register updates only on a valid final stage, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (stage[NST-1].valid) begin
      q <= stage[NST-1].data;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/asi_usr_ram.sv
// asi_usr_ram: single-port byte-strobed RAM slave on the asi usr_* bus with
// SLV_WS-cycle read latency, combinational size flags and a sticky
// out-of-range flag. Optional macro ASI_USR_RAM_STATS_EN adds saturating
// read/write cycle counters (rd_cnt, wr_cnt).
module asi_usr_ram
  import asi_usr_ram_pkg::*;
#(
  parameter int AXI_DW    = 128,
  parameter int AXI_AW    = 40,
  parameter int AXI_SW    = 3,
  parameter int SLV_WS    = 1,
  parameter int RAM_DEPTH = 1024,
  parameter int MIN_SIZE  = 0
) (
  input  logic               usr_clk,
  input  logic               usr_reset_n,
  asi_usr_ram_if.slave       usr,
  output logic               oor_err,
  input  logic               oor_clr
`ifdef ASI_USR_RAM_STATS_EN
  ,
  output logic [31:0]        rd_cnt,
  output logic [31:0]        wr_cnt
`endif
);

  localparam int AXI_BYTES  = AXI_DW / 8;
  localparam int AXI_WSTRBW = AXI_BYTES;
  localparam int BO         = $clog2(AXI_BYTES);
  localparam int RAW        = $clog2(RAM_DEPTH);

  logic [AXI_DW-1:0] mem [RAM_DEPTH];

  logic [RAW-1:0]    idx;
  logic              in_range;
  logic              access;
  logic              is_write;
  logic              is_read;
  logic              wr_en;
  logic [AXI_DW-1:0] rd_data;
  logic              unused_offset;

  // Lane alignment is carried by usr_wen, so the byte offset is not decoded.
  assign unused_offset = ^usr.usr_a[BO-1:0];

  assign idx      = usr.usr_a[BO+RAW-1:BO];
  assign in_range = (usr.usr_a[AXI_AW-1:BO+RAW] == '0);
  assign access   = ~usr.usr_cen;
  assign is_write = access & (usr.usr_wen != {AXI_WSTRBW{1'b1}});
  assign is_read  = access & (usr.usr_wen == {AXI_WSTRBW{1'b1}});
  assign wr_en    = is_write & in_range;
  assign rd_data  = in_range ? mem[idx] : {AXI_DW{1'b0}};

  assign usr.usr_wsize_error = size_error(8'(usr.usr_wsize), BO, MIN_SIZE);
  assign usr.usr_rsize_error = size_error(8'(usr.usr_rsize), BO, MIN_SIZE);

  // Byte-lane writes into the array; contents are deliberately not reset.
  always_ff @(posedge usr_clk) begin
    if (wr_en) begin
      for (int i = 0; i < AXI_BYTES; i++) begin
        if (!usr.usr_wen[i]) begin
          mem[idx][8*i +: 8] <= usr.usr_d[8*i +: 8];
        end
      end
    end
  end

  asi_usr_ram_rdpipe #(
    .DEPTH (SLV_WS)
  ) u_rdpipe (
    .clk     (usr_clk),
    .rst_n   (usr_reset_n),
    .launch  (is_read),
    .rd_data (rd_data),
    .q       (usr.usr_q)
  );

  // Sticky out-of-range flag; a new violation wins over a same-cycle clear.
  always_ff @(posedge usr_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) begin
      oor_err <= 1'b0;
    end else if (access && !in_range) begin
      oor_err <= 1'b1;
    end else if (oor_clr) begin
      oor_err <= 1'b0;
    end else begin
      oor_err <= oor_err;
    end
  end

`ifdef ASI_USR_RAM_STATS_EN
  // Saturating count of launched read cycles, cleared with the sticky flag.
  always_ff @(posedge usr_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) begin
      rd_cnt <= 32'd0;
    end else if (oor_clr) begin
      rd_cnt <= 32'd0;
    end else if (is_read && (rd_cnt != 32'hFFFF_FFFF)) begin
      rd_cnt <= rd_cnt + 32'd1;
    end else begin
      rd_cnt <= rd_cnt;
    end
  end

  // Saturating count of write cycles, cleared with the sticky flag.
  always_ff @(posedge usr_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) begin
      wr_cnt <= 32'd0;
    end else if (oor_clr) begin
      wr_cnt <= 32'd0;
    end else if (is_write && (wr_cnt != 32'hFFFF_FFFF)) begin
      wr_cnt <= wr_cnt + 32'd1;
    end else begin
      wr_cnt <= wr_cnt;
    end
  end
`endif

  asi_usr_ram_chk u_chk (
    .clk   (usr_clk),
    .rst_n (usr_reset_n),
    .cen   (usr.usr_cen)
  );

endmodule

// File: tb/tb_asi_usr_ram.sv
// tb_asi_usr_ram: directed self-checking bench. Three instances share one
// stimulus bus: dut1 (SLV_WS=1), dut2 (SLV_WS=2, own reset), dut3 (SLV_WS=3,
// MIN_SIZE=2).
module tb_asi_usr_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         rst2_n;
  logic [39:0]  a;
  logic         cen;
  logic [127:0] d;
  logic [15:0]  wen;
  logic [2:0]   wsize;
  logic [2:0]   rsize;
  logic         oor_clr;
  logic         oor1, oor2, oor3;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] D5  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] DN  = 128'hCAFEF00D_11223344_55667788_99AABBCC;
  localparam logic [127:0] D1  = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] D2  = 128'hA5A5A5A5_5A5A5A5A_A5A5A5A5_5A5A5A5A;
  localparam logic [127:0] D3  = 128'hDEADBEEF_00000001_FEDCBA98_76543210;
  localparam logic [127:0] W7  = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_00000000;
  localparam logic [39:0]  OOR = 40'h00_0000_4000;

  asi_usr_ram_if bus1 ();
  asi_usr_ram_if bus2 ();
  asi_usr_ram_if bus3 ();

  assign bus1.usr_a = a;  assign bus1.usr_cen = cen;  assign bus1.usr_d = d;
  assign bus1.usr_wen = wen;  assign bus1.usr_wsize = wsize;  assign bus1.usr_rsize = rsize;
  assign bus2.usr_a = a;  assign bus2.usr_cen = cen;  assign bus2.usr_d = d;
  assign bus2.usr_wen = wen;  assign bus2.usr_wsize = wsize;  assign bus2.usr_rsize = rsize;
  assign bus3.usr_a = a;  assign bus3.usr_cen = cen;  assign bus3.usr_d = d;
  assign bus3.usr_wen = wen;  assign bus3.usr_wsize = wsize;  assign bus3.usr_rsize = rsize;

  asi_usr_ram #(.SLV_WS(1)) dut1 (
    .usr_clk(clk), .usr_reset_n(rst_n), .usr(bus1), .oor_err(oor1), .oor_clr(oor_clr)
  );
  asi_usr_ram #(.SLV_WS(2)) dut2 (
    .usr_clk(clk), .usr_reset_n(rst2_n), .usr(bus2), .oor_err(oor2), .oor_clr(oor_clr)
  );
  asi_usr_ram #(.SLV_WS(3), .MIN_SIZE(2)) dut3 (
    .usr_clk(clk), .usr_reset_n(rst_n), .usr(bus3), .oor_err(oor3), .oor_clr(oor_clr)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int word, input logic [127:0] data, input logic [15:0] mask);
    a = 40'(word) << 4; cen = 1'b0; wen = mask; d = data;
    cyc();
    cen = 1'b1; wen = 16'hFFFF;
  endtask

  task automatic rd(input int word);
    a = 40'(word) << 4; cen = 1'b0; wen = 16'hFFFF;
    cyc();
    cen = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst2_n = 1'b0; cen = 1'b1; wen = 16'hFFFF; a = 40'd0; d = 128'd0;
    wsize = 3'd4; rsize = 3'd4; oor_clr = 1'b0;
    #12;
    checks++; if (bus1.usr_q !== 128'd0) begin errors++; $display("FAIL reset_q1 got=%h exp=0", bus1.usr_q); end
    checks++; if (bus2.usr_q !== 128'd0) begin errors++; $display("FAIL reset_q2 got=%h exp=0", bus2.usr_q); end
    checks++; if (bus3.usr_q !== 128'd0) begin errors++; $display("FAIL reset_q3 got=%h exp=0", bus3.usr_q); end
    checks++; if (oor1 !== 1'b0) begin errors++; $display("FAIL reset_oor got=%b exp=0", oor1); end
    @(negedge clk); rst_n = 1'b1; rst2_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic_rw();
    wr(5, D5, 16'h0000);
    checks++; if (bus1.usr_q !== 128'd0) begin errors++; $display("FAIL basic_pre q=%h exp=0", bus1.usr_q); end
    rd(5);
    checks++; if (bus1.usr_q !== 128'd0) begin errors++; $display("FAIL basic_early q=%h exp=0", bus1.usr_q); end
    cyc();
    checks++; if (bus1.usr_q !== D5) begin errors++; $display("FAIL basic_rd q=%h exp=%h", bus1.usr_q, D5); end
  endtask

  task automatic test_byte_strobe();
    wr(7, {128{1'b1}}, 16'h0000);
    wr(7, 128'd0, 16'hFFF0);
    rd(7);
    cyc();
    checks++; if (bus1.usr_q !== W7) begin errors++; $display("FAIL strobe q=%h exp=%h", bus1.usr_q, W7); end
  endtask

  task automatic test_back_to_back();
    wr(1, D1, 16'h0000);
    wr(2, D2, 16'h0000);
    wr(3, D3, 16'h0000);
    a = 40'(1) << 4; cen = 1'b0; wen = 16'hFFFF; cyc();
    a = 40'(2) << 4; cyc();
    a = 40'(3) << 4; cyc();
    cen = 1'b1;
    checks++; if (bus3.usr_q !== W7) begin errors++; $display("FAIL b2b_hold q=%h exp=%h", bus3.usr_q, W7); end
    cyc();
    checks++; if (bus3.usr_q !== D1) begin errors++; $display("FAIL b2b_d1 q=%h exp=%h", bus3.usr_q, D1); end
    cyc();
    checks++; if (bus3.usr_q !== D2) begin errors++; $display("FAIL b2b_d2 q=%h exp=%h", bus3.usr_q, D2); end
    cyc();
    checks++; if (bus3.usr_q !== D3) begin errors++; $display("FAIL b2b_d3 q=%h exp=%h", bus3.usr_q, D3); end
    cyc();
    checks++; if (bus3.usr_q !== D3) begin errors++; $display("FAIL b2b_keep q=%h exp=%h", bus3.usr_q, D3); end
  endtask

  task automatic test_size();
    wsize = 3'd5; #1;
    checks++; if (bus1.usr_wsize_error !== 1'b1) begin errors++; $display("FAIL wsize5 got=%b exp=1", bus1.usr_wsize_error); end
    wsize = 3'd4; #1;
    checks++; if (bus1.usr_wsize_error !== 1'b0) begin errors++; $display("FAIL wsize4 got=%b exp=0", bus1.usr_wsize_error); end
    rsize = 3'd1; #1;
    checks++; if (bus3.usr_rsize_error !== 1'b1) begin errors++; $display("FAIL rsize1_min2 got=%b exp=1", bus3.usr_rsize_error); end
    checks++; if (bus1.usr_rsize_error !== 1'b0) begin errors++; $display("FAIL rsize1_min0 got=%b exp=0", bus1.usr_rsize_error); end
    rsize = 3'd2; wsize = 3'd0; #1;
    checks++; if (bus3.usr_rsize_error !== 1'b0) begin errors++; $display("FAIL rsize2_min2 got=%b exp=0", bus3.usr_rsize_error); end
    checks++; if (bus3.usr_wsize_error !== 1'b1) begin errors++; $display("FAIL wsize0_min2 got=%b exp=1", bus3.usr_wsize_error); end
    rsize = 3'd7; #1;
    checks++; if (bus1.usr_rsize_error !== 1'b1) begin errors++; $display("FAIL rsize7 got=%b exp=1", bus1.usr_rsize_error); end
    wsize = 3'd4; rsize = 3'd4; #1;
  endtask

  task automatic test_oor();
    a = OOR | (40'(5) << 4); cen = 1'b0; wen = 16'hFFFF;
    cyc();
    cen = 1'b1;
    checks++; if (oor1 !== 1'b1) begin errors++; $display("FAIL oor_set got=%b exp=1", oor1); end
    cyc();
    checks++; if (bus1.usr_q !== 128'd0) begin errors++; $display("FAIL oor_rd_q q=%h exp=0", bus1.usr_q); end
    checks++; if (oor1 !== 1'b1) begin errors++; $display("FAIL oor_sticky got=%b exp=1", oor1); end
    a = OOR | (40'(5) << 4); cen = 1'b0; wen = 16'h0000; d = {128{1'b1}};
    cyc();
    cen = 1'b1; wen = 16'hFFFF;
    rd(5);
    cyc();
    checks++; if (bus1.usr_q !== D5) begin errors++; $display("FAIL oor_wr_dropped q=%h exp=%h", bus1.usr_q, D5); end
    a = OOR; cen = 1'b0; oor_clr = 1'b1;
    cyc();
    cen = 1'b1;
    checks++; if (oor1 !== 1'b1) begin errors++; $display("FAIL oor_set_wins got=%b exp=1", oor1); end
    cyc();
    oor_clr = 1'b0;
    checks++; if (oor1 !== 1'b0) begin errors++; $display("FAIL oor_clr got=%b exp=0", oor1); end
  endtask

  task automatic test_write_after_read();
    rd(5);
    wr(5, DN, 16'h0000);
    checks++; if (bus1.usr_q !== D5) begin errors++; $display("FAIL war_old q=%h exp=%h", bus1.usr_q, D5); end
    rd(5);
    cyc();
    checks++; if (bus1.usr_q !== DN) begin errors++; $display("FAIL war_new q=%h exp=%h", bus1.usr_q, DN); end
  endtask

  task automatic test_reset_midread();
    cyc(); cyc(); cyc();
    checks++; if (bus2.usr_q !== DN) begin errors++; $display("FAIL rmr_pre q=%h exp=%h", bus2.usr_q, DN); end
    rd(5);
    rst2_n = 1'b0;
    #1;
    checks++; if (bus2.usr_q !== 128'd0) begin errors++; $display("FAIL rmr_async q=%h exp=0", bus2.usr_q); end
    cyc();
    @(negedge clk); rst2_n = 1'b1;
    cyc();
    checks++; if (bus2.usr_q !== 128'd0) begin errors++; $display("FAIL rmr_stale1 q=%h exp=0", bus2.usr_q); end
    cyc();
    checks++; if (bus2.usr_q !== 128'd0) begin errors++; $display("FAIL rmr_stale2 q=%h exp=0", bus2.usr_q); end
    rd(5);
    checks++; if (bus2.usr_q !== 128'd0) begin errors++; $display("FAIL rmr_new0 q=%h exp=0", bus2.usr_q); end
    cyc();
    checks++; if (bus2.usr_q !== 128'd0) begin errors++; $display("FAIL rmr_new1 q=%h exp=0", bus2.usr_q); end
    cyc();
    checks++; if (bus2.usr_q !== DN) begin errors++; $display("FAIL rmr_new2 q=%h exp=%h", bus2.usr_q, DN); end
  endtask

  initial begin
    test_reset();
    test_basic_rw();
    test_byte_strobe();
    test_back_to_back();
    test_size();
    test_oor();
    test_write_after_read();
    test_reset_midread();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
